// File: rtl/psum_glb_port_arb.sv
// Single-port psum GLB arbiter: read-priority scheduling with a buffered write path,
// read-after-write hazard blocking, forced drains and a tag-aligned read-return pipeline.
module psum_glb_port_arb #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned STARVE_LIM  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rd_req,
  input  logic [ADDR_W-1:0]              i_rd_addr,
  input  logic [TAG_W-1:0]               i_rd_tag,
  output logic                           o_rd_ready,
  input  logic                           i_wr_req,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [DATA_W-1:0]              i_wr_data,
  output logic                           o_wr_ready,
  input  logic                           i_drain,
  output logic                           o_glb_re,
  output logic                           o_glb_we,
  output logic [ADDR_W-1:0]              o_glb_addr,
  output logic [DATA_W-1:0]              o_glb_wdata,
  input  logic [DATA_W-1:0]              i_glb_rdata,
  output logic                           o_rd_valid,
  output logic [DATA_W-1:0]              o_rd_data,
  output logic [TAG_W-1:0]               o_rd_tag,
  output logic [$clog2(WFIFO_DEPTH):0]   o_wfifo_cnt,
  output logic                           o_idle
);

  localparam int unsigned PtrW = $clog2(WFIFO_DEPTH);
  localparam int unsigned CntW = $clog2(WFIFO_DEPTH) + 1;
  localparam int unsigned StvW = $clog2(STARVE_LIM) + 1;

  typedef enum logic {StRdPri, StWrDrain} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [StvW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
  logic [RD_LAT-1:0] ret_vld_q;
  logic [TAG_W-1:0]  ret_tag_q [RD_LAT];

  logic              wr_ready, push, pop, hz, rd_ready, glb_re, glb_we;
  logic [PtrW-1:0]   ent_off [WFIFO_DEPTH];

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    hz = 1'b0;
    for (int unsigned i = 0; i < WFIFO_DEPTH; i++) begin
      ent_off[i] = PtrW'(i) - rptr_q;
      if ((CntW'(ent_off[i]) < cnt_q) && (fifo_addr_q[i] == i_rd_addr)) begin
        hz = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ready = (cnt_q < CntW'(WFIFO_DEPTH));
    push     = i_wr_req && wr_ready;
    rd_ready = 1'b0;
    glb_re   = 1'b0;
    glb_we   = 1'b0;
    unique case (state_q)
      StRdPri: begin
        rd_ready = !hz;
        glb_re   = i_rd_req && !hz;
        glb_we   = !glb_re && (cnt_q != '0);
      end
      StWrDrain: begin
        glb_we = (cnt_q != '0);
      end
      default: ;
    endcase
    pop    = glb_we;
    cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;

    state_d = state_q;
    unique case (state_q)
      StRdPri: begin
        if ((cnt_d == CntW'(WFIFO_DEPTH)) || i_drain ||
            ((starve_q == StvW'(STARVE_LIM - 1)) && (cnt_q != '0))) begin
          state_d = StWrDrain;
        end
      end
      StWrDrain: begin
        if ((cnt_d == '0) && !i_drain) begin
          state_d = StRdPri;
        end
      end
      default: state_d = StRdPri;
    endcase

    if ((state_d != state_q) || glb_we) begin
      starve_d = '0;
    end else if ((state_q == StRdPri) && (cnt_q != '0)) begin
      starve_d = starve_q + StvW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StRdPri;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset: liveness comes from the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= i_wr_addr;
      fifo_data_q[wptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ret_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        ret_tag_q[i] <= '0;
      end
    end else begin
      ret_vld_q[0] <= glb_re;
      ret_tag_q[0] <= glb_re ? i_rd_tag : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        ret_vld_q[i] <= ret_vld_q[i-1];
        ret_tag_q[i] <= ret_tag_q[i-1];
      end
    end
  end

  assign o_rd_ready  = rd_ready;
  assign o_wr_ready  = wr_ready;
  assign o_glb_re    = glb_re;
  assign o_glb_we    = glb_we;
  assign o_glb_addr  = glb_re ? i_rd_addr : fifo_addr_q[rptr_q];
  assign o_glb_wdata = fifo_data_q[rptr_q];
  assign o_rd_valid  = ret_vld_q[RD_LAT-1];
  assign o_rd_tag    = ret_tag_q[RD_LAT-1];
  assign o_rd_data   = i_glb_rdata;
  assign o_wfifo_cnt = cnt_q;
  assign o_idle      = (cnt_q == '0) && (ret_vld_q == '0) && (state_q == StRdPri);

endmodule

// File: tb/tb_psum_glb_port_arb.sv
// Scoreboard bench for psum_glb_port_arb: directed stimulus pushes expected GLB strobes and
// read returns (with their cycle numbers); a negedge monitor pops and compares.
module tb_psum_glb_port_arb;
  localparam int DW = 16, AW = 16, TW = 8, DEPTH = 4, LAT = 2, SLIM = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, wr_req, drain;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [TW-1:0] rd_tag;
  logic [DW-1:0] wr_data;
  logic          rd_ready, wr_ready, glb_re, glb_we, rd_valid, idle;
  logic [AW-1:0] glb_addr;
  logic [DW-1:0] glb_wdata, glb_rdata, rd_data;
  logic [TW-1:0] rd_tag_o;
  logic [2:0]    wfifo_cnt;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psum_glb_port_arb #(
    .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .WFIFO_DEPTH(DEPTH), .RD_LAT(LAT), .STARVE_LIM(SLIM)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_tag(rd_tag), .o_rd_ready(rd_ready),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_drain(drain),
    .o_glb_re(glb_re), .o_glb_we(glb_we), .o_glb_addr(glb_addr), .o_glb_wdata(glb_wdata),
    .i_glb_rdata(glb_rdata),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_tag(rd_tag_o),
    .o_wfifo_cnt(wfifo_cnt), .o_idle(idle)
  );

  function automatic logic [15:0] iv(input logic [15:0] a);
    return {8'hE5, a[7:0]};
  endfunction

  // GLB bank model: unwritten words read as iv(addr), two-cycle read latency.
  logic          mdl_clr;
  logic [15:0]   mem [256];
  logic [255:0]  wflag;
  logic [15:0]   p0, p1;
  always @(posedge clk) begin
    if (mdl_clr) begin
      wflag <= '0;
    end else if (glb_we) begin
      mem[glb_addr[7:0]]   <= glb_wdata;
      wflag[glb_addr[7:0]] <= 1'b1;
    end
    p0 <= glb_re ? (wflag[glb_addr[7:0]] ? mem[glb_addr[7:0]] : iv(glb_addr)) : 16'h0;
    p1 <= p0;
  end
  assign glb_rdata = p1;

  typedef struct {
    logic [15:0] key;
    logic [15:0] data;
    int          cyc;
  } ev_t;
  ev_t q_rd[$];
  ev_t q_wr[$];
  ev_t q_ret[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected event, want none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (glb_re || glb_we) chk("re_we_excl", 32'(glb_re & glb_we), 32'd0);
    if (glb_re) begin
      if (q_rd.size() == 0) miss("glb_read");
      else begin
        e = q_rd.pop_front();
        chk("glb_rd_addr", 32'(glb_addr), 32'(e.key));
        chk("glb_rd_cyc", cyc, e.cyc);
      end
    end
    if (glb_we) begin
      if (q_wr.size() == 0) miss("glb_write");
      else begin
        e = q_wr.pop_front();
        chk("glb_wr_addr", 32'(glb_addr), 32'(e.key));
        chk("glb_wr_data", 32'(glb_wdata), 32'(e.data));
        chk("glb_wr_cyc", cyc, e.cyc);
      end
    end
    if (rd_valid) begin
      if (q_ret.size() == 0) miss("rd_return");
      else begin
        e = q_ret.pop_front();
        chk("ret_tag", 32'(rd_tag_o), 32'(e.key));
        chk("ret_data", 32'(rd_data), 32'(e.data));
        chk("ret_cyc", cyc, e.cyc);
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  // woff < 0: the write is not expected to reach the GLB. ecnt < 0: count not checked.
  task automatic step(input logic rq, input logic [15:0] ra, input logic [7:0] rt,
                      input logic rdy, input logic [15:0] rdat,
                      input logic wq, input logic [15:0] wa, input logic [15:0] wd,
                      input int woff, input logic dr, input int ecnt);
    ev_t e;
    rd_req = rq; rd_addr = ra; rd_tag = rt;
    wr_req = wq; wr_addr = wa; wr_data = wd;
    drain  = dr;
    if (rq && rdy) begin
      e = '{ra, 16'h0, cyc};
      q_rd.push_back(e);
      e = '{{8'h0, rt}, rdat, cyc + LAT};
      q_ret.push_back(e);
    end
    if (wq && woff >= 0) begin
      e = '{wa, wd, cyc + woff};
      q_wr.push_back(e);
    end
    @(negedge clk);
    chk("rd_ready", 32'(rd_ready), 32'(rdy));
    if (ecnt >= 0) begin
      chk("wfifo_cnt", 32'(wfifo_cnt), ecnt);
      chk("wr_ready", 32'(wr_ready), 32'(ecnt < DEPTH));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 16'h00FF, 8'h0, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, -1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_tag", 32'(rd_tag_o), 32'd0);
    chk("rst_glb_re", 32'(glb_re), 32'd0);
    chk("rst_glb_we", 32'(glb_we), 32'd0);
    chk("rst_cnt", 32'(wfifo_cnt), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    rd_req = 1'b0; rd_addr = 16'h00FF; rd_tag = 8'h0;
    wr_req = 1'b0; wr_addr = 16'h0; wr_data = 16'h0; drain = 1'b0;
    rst_n = 1'b0; mdl_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1; mdl_clr = 1'b0;
    @(posedge clk);
    #1;

    // Read stream: 5 back-to-back reads, returns two cycles later in order.
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'(i), 8'(8'h31 + i), 1'b1, iv(16'(i)), 1'b0, 16'h0, 16'h0, -1, 1'b0, 0);
    idle_n(3);
    chk("idle_after_reads", 32'(idle), 32'd1);

    // Writes only: each issues the cycle after it is pushed.
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h00FF, 8'h0, 1'b1, 16'h0, 1'b1, 16'(16'h10 + i), 16'(16'hA010 + i), 1,
           1'b0, (i == 0) ? 0 : 1);
    step(1'b0, 16'h00FF, 8'h0, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 1);
    step(1'b0, 16'h00FF, 8'h0, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 0);
    chk("idle_after_writes", 32'(idle), 32'd1);

    // Continuous reads + 4 writes: fill, 4-cycle drain with reads blocked, resume.
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'(16'h40 + i), 8'(8'h40 + i), 1'b1, iv(16'(16'h40 + i)),
           1'b1, 16'(16'h50 + i), 16'(16'hB050 + i), 4, 1'b0, i);
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'h44, 8'h44, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 4 - i);
    step(1'b1, 16'h44, 8'h44, 1'b1, iv(16'h44), 1'b0, 16'h0, 16'h0, -1, 1'b0, 0);
    idle_n(3);

    // RAW: read of a buffered address waits for its write.
    step(1'b0, 16'h00FF, 8'h0, 1'b1, 16'h0, 1'b1, 16'h20, 16'hBEEF, 1, 1'b0, 0);
    step(1'b1, 16'h20, 8'h77, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 1);
    step(1'b1, 16'h20, 8'h77, 1'b1, 16'hBEEF, 1'b0, 16'h0, 16'h0, -1, 1'b0, 0);
    idle_n(3);

    // Starvation: buffered write forced out after 8 starved cycles, one read blocked.
    step(1'b1, 16'h60, 8'h60, 1'b1, iv(16'h60), 1'b1, 16'h30, 16'hC030, 9, 1'b0, 0);
    for (int i = 1; i <= 8; i++)
      step(1'b1, 16'(16'h60 + i), 8'(8'h60 + i), 1'b1, iv(16'(16'h60 + i)),
           1'b0, 16'h0, 16'h0, -1, 1'b0, 1);
    step(1'b1, 16'h69, 8'h69, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 1);
    step(1'b1, 16'h69, 8'h69, 1'b1, iv(16'h69), 1'b0, 16'h0, 16'h0, -1, 1'b0, 0);
    idle_n(3);

    // Drain pulse with 2 entries, then async reset with returns and a write in flight.
    step(1'b1, 16'h70, 8'h70, 1'b1, iv(16'h70), 1'b1, 16'h38, 16'hD038, 3, 1'b0, 0);
    step(1'b1, 16'h71, 8'h71, 1'b1, iv(16'h71), 1'b1, 16'h39, 16'hD039, 3, 1'b0, 1);
    step(1'b1, 16'h72, 8'h72, 1'b1, iv(16'h72), 1'b0, 16'h0, 16'h0, -1, 1'b1, 2);
    step(1'b1, 16'h73, 8'h73, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 2);
    step(1'b1, 16'h73, 8'h73, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, -1, 1'b0, 1);
    step(1'b1, 16'h73, 8'h73, 1'b1, iv(16'h73), 1'b0, 16'h0, 16'h0, -1, 1'b0, 0);
    step(1'b1, 16'h74, 8'h74, 1'b1, iv(16'h74), 1'b1, 16'h3A, 16'hD03A, -1, 1'b0, 0);
    rd_req = 1'b0; rd_addr = 16'h00FF; wr_req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    chk("ret_pending_at_reset", 32'(q_ret.size()), 32'd2);
    q_ret.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_n(3);
    chk("idle_after_reset", 32'(idle), 32'd1);
    chk("cnt_after_reset", 32'(wfifo_cnt), 32'd0);

    chk("q_rd_empty", 32'(q_rd.size()), 32'd0);
    chk("q_wr_empty", 32'(q_wr.size()), 32'd0);
    chk("q_ret_empty", 32'(q_ret.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
